// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: reset flush sequence, load-use bubbles,
// taken-branch squash and a fixed-length divide stall, plus a stall counter.
module hazard_ctrl #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter bit          DEBUG      = 1'b0
) (
  input  logic        clk,
  input  logic        async_rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        ex_div_start,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        div_busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {INIT, RUN, DIV_WAIT} state_e;

  // First divide stall cycle happens in RUN, so the counter covers the rest.
  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

  state_e      state_q;
  logic [1:0]  init_cnt_q;
  logic [7:0]  div_cnt_q;
  logic [31:0] stall_q;

  logic unused_debug;
  assign unused_debug = DEBUG;

  logic load_use;
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b1;
    idex_flush  = 1'b1;
    exmem_flush = 1'b1;
    memwb_flush = 1'b1;
    div_busy    = 1'b0;
    if (state_q != INIT) begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      if ((state_q == RUN && !ex_branch_taken && ex_div_start) ||
          (state_q == DIV_WAIT && div_cnt_q != 8'd0)) begin
        // Freeze the front of the pipe, bubble into MEM, let WB drain.
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b1;
        div_busy    = 1'b1;
      end else if (state_q == RUN && ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (state_q == RUN && load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge async_rst) begin
    if (!async_rst) begin
      state_q    <= INIT;
      init_cnt_q <= 2'd0;
      div_cnt_q  <= 8'd0;
      stall_q    <= 32'd0;
    end else begin
      if (state_q != INIT && !pc_en)
        stall_q <= stall_q + 32'd1;
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + 2'd1;
          if (init_cnt_q == 2'd1) state_q <= RUN;
        end
        RUN: begin
          if (!ex_branch_taken && ex_div_start) begin
            div_cnt_q <= DIV_LOAD;
            state_q   <= DIV_WAIT;
          end
        end
        DIV_WAIT: begin
          if (div_cnt_q != 8'd0) div_cnt_q <= div_cnt_q - 8'd1;
          else                   state_q   <= RUN;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with DIV_CYCLES=4; outputs are packed as
// {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem,memwb flushes, div_busy}.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        async_rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken, ex_div_start;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, div_busy;
  logic [31:0] stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [9:0] O_INIT = 10'b00000_1111_0;
  localparam logic [9:0] O_RUN  = 10'b11111_0000_0;
  localparam logic [9:0] O_LU   = 10'b00111_0100_0;
  localparam logic [9:0] O_BR   = 10'b11111_1100_0;
  localparam logic [9:0] O_DIV  = 10'b00001_0010_1;

  hazard_ctrl #(.DIV_CYCLES(4), .DEBUG(1'b0)) dut (
    .clk(clk), .async_rst(async_rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_div_start(ex_div_start),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .div_busy(div_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  logic [9:0] outs;
  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, memwb_flush, div_busy};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ex_div_start = 1'b0;
  endtask

  task automatic set_lu();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
  endtask

  // Advance one clock edge and return on the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    async_rst = 1'b0;
    idle();
    #3;
    chk("rst_outs", 32'(outs), 32'(O_INIT));
    chk("rst_stall", stall_cycles, 32'd0);
    cyc();
    async_rst = 1'b1; #1;
    chk("init0", 32'(outs), 32'(O_INIT));
    cyc(); #1;
    chk("init1", 32'(outs), 32'(O_INIT));
    cyc(); #1;
    chk("run", 32'(outs), 32'(O_RUN));
    chk("run_stall", stall_cycles, 32'd0);

    // Load-use on rs2
    set_lu(); #1;
    chk("lu", 32'(outs), 32'(O_LU));
    cyc(); idle(); #1;
    chk("lu_after", 32'(outs), 32'(O_RUN));
    chk("lu_stall", stall_cycles, 32'd1);

    // ex_rd == 0 never stalls
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_rs2_used = 1'b1; id_rs1_used = 1'b1; #1;
    chk("rd0", 32'(outs), 32'(O_RUN));
    // matching rs1 not used
    ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b0; id_rs2 = 5'd3; #1;
    chk("rs1_unused", 32'(outs), 32'(O_RUN));
    id_rs1_used = 1'b1; #1;
    chk("lu_rs1", 32'(outs), 32'(O_LU));
    idle();
    cyc(); #1;
    chk("rd0_stall", stall_cycles, 32'd1);

    // Branch beats load-use and divide
    set_lu(); ex_branch_taken = 1'b1; ex_div_start = 1'b1; #1;
    chk("br_prio", 32'(outs), 32'(O_BR));
    cyc(); idle(); #1;
    chk("br_run", 32'(outs), 32'(O_RUN));
    chk("br_stall", stall_cycles, 32'd1);

    // Divide: 4 stall cycles then one release
    ex_div_start = 1'b1; #1;
    chk("div1", 32'(outs), 32'(O_DIV));
    cyc(); idle(); #1;
    chk("div2", 32'(outs), 32'(O_DIV));
    cyc(); ex_branch_taken = 1'b1; ex_div_start = 1'b1; #1;
    chk("div3_ign", 32'(outs), 32'(O_DIV));
    cyc(); idle(); #1;
    chk("div4", 32'(outs), 32'(O_DIV));
    cyc(); set_lu(); ex_div_start = 1'b1; #1;
    chk("div_rel", 32'(outs), 32'(O_RUN));
    cyc(); ex_div_start = 1'b0; #1;
    chk("lu_after_rel", 32'(outs), 32'(O_LU));
    cyc(); idle(); #1;
    chk("div_stall", stall_cycles, 32'd6);

    // Reset in the middle of a divide (counter at 2)
    ex_div_start = 1'b1;
    cyc(); idle();
    cyc();
    async_rst = 1'b0; #1;
    chk("mid_rst_outs", 32'(outs), 32'(O_INIT));
    chk("mid_rst_busy", 32'(div_busy), 32'd0);
    chk("mid_rst_stall", stall_cycles, 32'd0);
    cyc();
    async_rst = 1'b1; #1;
    chk("re_init0", 32'(outs), 32'(O_INIT));
    cyc(); #1;
    chk("re_init1", 32'(outs), 32'(O_INIT));
    cyc(); #1;
    chk("re_run", 32'(outs), 32'(O_RUN));

    // Counter wrap
    force dut.stall_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_q;
    #1;
    chk("preload", stall_cycles, 32'hFFFF_FFFF);
    set_lu();
    cyc(); idle(); #1;
    chk("wrap", stall_cycles, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
